// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level and the
// bit-period helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE = 1'b1;

  // Rounded clocks per bit so the baud error stays within half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count; restart holds it at zero.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter with a one-entry holding register so queued
// bytes follow the previous stop bit with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_byte_tx: fewer than 4 clocks per bit");
  end

  uart_state_t state;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic [7:0]  shift;
  logic        parity_bit;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        tick;
  logic        last_stop;
  logic        load;

  assign last_stop = (state == ST_STOP) && tick && (stop_idx == STOP_LAST);
  assign load      = hold_full && ((state == ST_IDLE) || last_stop);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .restart(state == ST_IDLE),
    .tick   (tick)
  );

  // A handshake on the same edge as a load wins: the old byte has already
  // been copied into the shift register, so the register stays full.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      tx_ready  <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
      tx_ready  <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      tx_ready  <= ~hold_full;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      uart_tx    <= UART_IDLE;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (load) begin
        shift      <= hold_data;
        parity_bit <= (^hold_data) ^ PAR_ODD;
      end
      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            state   <= ST_START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            uart_tx <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PAR_EN) begin
                state   <= ST_PARITY;
                uart_tx <= parity_bit;
              end else begin
                state   <= ST_STOP;
                uart_tx <= UART_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            uart_tx <= UART_IDLE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == STOP_LAST) begin
              tx_done <= 1'b1;
              if (hold_full) begin
                state   <= ST_START;
                uart_tx <= 1'b0;
              end else begin
                state   <= ST_IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= UART_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: four configurations (8N1, 8E1, 8O1, 8N2) driven
// with directed and random bytes, checked cycle by cycle against a frame model.
module tb_uart_byte_tx;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          phase    = 0;
  int          drv_done = 0;
  bit          chk_on   = 1'b0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  for (genvar i = 0; i < 4; i++) begin : g_cfg
    localparam int unsigned PE  = (i == 1 || i == 2) ? 1 : 0;
    localparam int unsigned PO  = (i == 2) ? 1 : 0;
    localparam int unsigned SB  = (i == 3) ? 2 : 1;
    localparam int unsigned CPB = 10;
    localparam int          FL  = CPB * (10 + PE + SB - 1);

    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, tx_busy, tx_done;

    // Model: position inside the current frame (-1 when idle) plus holding slot.
    int          pos    = -1;
    logic [7:0]  fbyte  = 8'h00;
    logic [7:0]  hbyte  = 8'h00;
    bit          hfull  = 1'b0;
    bit          rdy    = 1'b0;
    bit          done_m = 1'b0;
    bit          acc;
    int unsigned acc_cnt      = 0;
    int unsigned dut_done_cnt = 0;

    uart_byte_tx #(
      .CLK_FREQ  (50_000_000),
      .BAUD_RATE (5_000_000),
      .PARITY_EN (PE),
      .PARITY_ODD(PO),
      .STOP_BITS (SB)
    ) u_dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .uart_tx (uart_tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
    );

    function automatic logic exp_line(input int p, input logic [7:0] b);
      int k;
      if (p < 0) return 1'b1;
      k = p / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && PE == 1) return (^b) ^ (PO == 1);
      return 1'b1;
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        pos = -1; hfull = 1'b0; rdy = 1'b0; done_m = 1'b0;
      end else begin
        acc    = tx_valid && rdy;
        done_m = 1'b0;
        if (pos >= 0) begin
          pos++;
          if (pos == FL) begin
            done_m = 1'b1;
            pos    = -1;
          end
        end
        if (pos < 0 && hfull) begin
          pos   = 0;
          fbyte = hbyte;
          hfull = 1'b0;
        end
        if (acc) begin
          hfull = 1'b1;
          hbyte = tx_data;
          acc_cnt++;
        end
        rdy = !hfull;
      end
    end

    always @(negedge sys_clk) begin
      if (chk_on) begin
        check_eq($sformatf("cfg%0d_line", i),  uart_tx,  exp_line(pos, fbyte));
        check_eq($sformatf("cfg%0d_busy", i),  tx_busy,  pos >= 0);
        check_eq($sformatf("cfg%0d_done", i),  tx_done,  done_m);
        check_eq($sformatf("cfg%0d_ready", i), tx_ready, rdy);
        if (tx_done) dut_done_cnt++;
      end
    end

    // Called at a negedge; returns at the negedge after acceptance, valid still high.
    task automatic send(input logic [7:0] b);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 1000) begin
        @(negedge sys_clk);
        n++;
      end
      check_eq($sformatf("cfg%0d_send_wait", i), n < 1000, 1);
      @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
      tx_valid = 1'b0;
      repeat (n) @(negedge sys_clk);
    endtask

    initial begin
      wait (phase == 1);
      @(negedge sys_clk);
      send(8'h55); idle(150);
      send(8'hA3); send(8'h3C); idle(300);
      send(8'h07); idle(150);
      send(8'hFF); send(8'h5A); idle(300);
      send(8'h11); send(8'h22); send(8'h33); idle(400);
      for (int r = 0; r < 12; r++) begin
        send(8'($urandom));
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 140));
      end
      idle(1);
      drv_done++;
      wait (phase == 2);
      send(8'h0F);
      tx_valid = 1'b0;
      wait (phase == 3);
      send(8'h81);
      tx_valid = 1'b0;
      wait (phase == 4);
      check_eq($sformatf("cfg%0d_frames", i), dut_done_cnt, acc_cnt - 1);
    end
  end

  initial begin
    #3 sys_rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    phase   = 1;
    wait (drv_done == 4);
    repeat (300) @(negedge sys_clk);
    phase = 2;
    repeat (46) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check_eq("rst_async_line", g_cfg[0].uart_tx, 1);
    check_eq("rst_async_busy", g_cfg[0].tx_busy, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    phase   = 3;
    repeat (300) @(negedge sys_clk);
    phase = 4;
    repeat (2) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte-wide UART transmitter: accepts 8-bit bytes over a valid/ready handshake and serialises them onto `uart_tx` as start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits. It is the transmit half of the board UART, alongside the existing receive path inside `uart_top`, and drives the FPGA `uart_tx` pin. A one-entry holding register lets back-to-back bytes go out with no idle gap between frames.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `PARITY_EN`, 0: 1 inserts a parity bit after D7.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: 1 or 2; any other value is an elaboration error.

Ports:
- `sys_clk`, in, 1: the single clock.
- `sys_rst`, in, 1: reset, asynchronous, active-high.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: holding register empty; a byte is accepted when `tx_valid` and `tx_ready` are both high on an edge.
- `uart_tx`, out, 1: serial line, idles high, registered.
- `tx_busy`, out, 1: high while a frame is on the line.
- `tx_done`, out, 1: one-cycle pulse at the end of each frame.

## Operation

- Bit period: `CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE`, fixed at elaboration. A value below 4 is an elaboration error.
- Bit counter: counts 0 to `CLKS_PER_BIT`-1, then wraps.
- Holding register: loaded on the handshake. `hold_full` is set on the handshake and cleared when the byte moves to the shift register.
- FSM states:
  - IDLE: `uart_tx` = 1. If `hold_full`, the next edge goes to START and loads the shift register.
  - START: `uart_tx` = 0 for one bit period, then DATA.
  - DATA: 8 bit periods, shift register LSB on `uart_tx`, shifting right each period. After bit 7, go to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: one bit period. Even parity bit = XOR of the 8 data bits; odd parity bit = XNOR of the 8 data bits.
  - STOP: `uart_tx` = 1 for `STOP_BITS` bit periods. On the last cycle:
    - if `hold_full`: go straight to START and load the next byte (zero idle gap);
    - otherwise: go to IDLE.
- Handshake rules:
  - While `tx_ready` = 0, the source holds `tx_valid` and `tx_data` stable.
  - A new byte can be accepted during any frame, as long as the holding register is empty.
  - When a handshake and a shift-register load fall on the same edge, the new byte is held and the old byte transferred; the holding register ends full and nothing is lost.
- Reset, including mid-frame:
  - `uart_tx` goes to 1 immediately (asynchronous).
  - Outputs: `tx_busy` = 0, `tx_done` = 0, `tx_ready` = 0.
  - FSM goes to IDLE; holding register and counters clear; a partial frame is dropped with no `tx_done`.
  - `tx_ready` rises on the first edge after `sys_rst` is released.

## Timing

- Latency: handshake at edge k with the FSM in IDLE and holding register empty → `hold_full` set after edge k → `uart_tx` falls after edge k+1 (start of START).
- Frame length: `CLKS_PER_BIT` × (10 + `PARITY_EN` + `STOP_BITS` − 1) cycles. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- `tx_busy`: high from START entry through the last STOP cycle. It stays high across back-to-back frames.
- `tx_done`: high in the cycle after the last STOP cycle, for exactly one cycle. On a back-to-back transition this is the first START cycle of the next frame.
- `tx_ready`: equals `~hold_full`, registered. It re-asserts in the cycle after the transfer to the shift register.

## Structure

- Package `uart_pkg`, shared with the receive path, holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - the `UART_IDLE` = 1'b1 constant;
  - the `clks_per_bit(clk_freq, baud)` function.
- Sub-module `uart_baud_cnt`: a bit-period counter with `restart` input and `tick` output. The receive side reuses it.
- Everything else (FSM, holding register, shift register, parity, outputs) sits in `uart_byte_tx`.

## Test plan

All scenarios use `CLK_FREQ` = 50_000_000 and `BAUD_RATE` = 5_000_000, giving 10 cycles per bit.

- 8N1, send 0x55 → `uart_tx` reads 0,1,0,1,0,1,0,1,0,1, each held 10 cycles, starting 2 edges after the handshake. `tx_done` pulses once, 100 cycles after the start bit falls.
- Back-to-back: 0xA3 sent, then 0x3C offered while 0xA3 is still transmitting → second start bit immediately follows the first stop bit with no idle cycle. `tx_busy` stays high for 200 cycles; `tx_done` pulses twice.
- `PARITY_EN` = 1, send 0x07 → parity bit 1 with even parity, 0 with `PARITY_ODD` = 1. Frame is 110 cycles.
- `STOP_BITS` = 2, send 0xFF → line high for 20 cycles after D7, and `tx_done` at cycle 110. A queued byte's start bit follows immediately after.
- Stall: `tx_valid` held with 0x11, then 0x22, then 0x33 during a busy frame → `tx_ready` is low until each transfer. Bytes appear in order 0x11, 0x22, 0x33 with no loss or duplication.
- Reset mid-frame: `sys_rst` asserted during data bit 3 of 0x0F → `uart_tx` = 1 in the same cycle and no `tx_done`. After release, `tx_ready` = 1 on the first edge, and the next byte (0x81) is sent correctly.
